vector_cegen: RTL
=================

Name: vector_cegen

Overview:
Parametrised clock-enable generator for the Vector-06C core. It runs on the 24 MHz system clock and produces the video pixel and slice enables, the CPU enable pair, and the timer enable. Unlike the fixed-rate generator it replaces, it adds an asynchronous active-low reset, a programmable start-up delay, and a runtime-selectable CPU rate (1.5/3/6 MHz). It also provides a glitch-free CPU pause handshake. It sits between the PLL/clock-divider wrapper and the CPU, video and timer blocks.

Parameters:
CTR_W, 6, phase counter width; legal range 5..8; counter MSB drives pipe_ab.
INIT_CYCLES, 3, clocks after reset release before the counter starts; legal range 1..31.
DEFAULT_SPEED, 2'd0, CPU rate loaded at reset (0=3 MHz, 1=6 MHz, 2=1.5 MHz).

Ports:
clk24  in  1  system clock, 24 MHz; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
cpu_speed  in  2  requested CPU rate: 0=3 MHz, 1=6 MHz, 2=1.5 MHz, 3=treated as 0.
hold_req  in  1  level request to freeze the CPU enables.
hold_ack  out  1  high while the CPU enables are frozen.
ready  out  1  high once the start-up delay has elapsed.
ce12  out  1  pixel enable, 12 MHz.
ce6  out  1  pixel enable, 6 MHz.
ce6x  out  1  pre-pixel enable, 6 MHz, one clock before ce6.
video_slice  out  1  video memory slice, high for 4 of every 8 clocks.
pipe_ab  out  1  pipe A/B select.
ce_cpu  out  1  CPU enable at the selected rate.
ce_cpu_f2  out  1  CPU phase-2 enable, always one clock after ce_cpu.
ce1m5  out  1  timer enable, fixed at 1.5 MHz.
phase  out  CTR_W  current counter value, for debug and alignment.

Behaviour:
- Reset: reset_n low asynchronously clears the init counter, the phase counter and every output register. The paused flag clears to 0. The active speed loads DEFAULT_SPEED.
- Start-up: the init counter increments each clock until it equals INIT_CYCLES, then holds.
  - ready = (init counter == INIT_CYCLES).
  - The phase counter and all enables stay 0 until ready is high.
- Counting: while ready, the phase counter (ctr) increments every clock and wraps modulo 2^CTR_W.
- Output latency: every enable is registered from the current ctr value, so it appears one clock after that value. Decodes:
  - ce12 = ctr[0].
  - ce6 = ctr[1] & ctr[0].
  - ce6x = ctr[1] & ~ctr[0].
  - video_slice = ~ctr[2].
  - pipe_ab = ctr[CTR_W-1].
  - ce1m5 = (ctr[3:0] == 4'b0110).
- CPU enables, by active speed. Each is additionally gated by ~paused.
  - 6 MHz: ce_cpu when ctr[1:0]==2'b10; ce_cpu_f2 when ctr[1:0]==2'b11.
  - 3 MHz: ce_cpu when ctr[2:0]==3'b110; ce_cpu_f2 when ctr[2:0]==3'b111.
  - 1.5 MHz: ce_cpu when ctr[3:0]==4'b0110; ce_cpu_f2 when ctr[3:0]==4'b0111.
- Window boundary = clock where ctr[3:0]==4'b1111.
  - cpu_speed and hold_req are sampled only at the boundary.
  - The active speed and paused register update on that edge and govern decodes from ctr[3:0]==0 onward.
  - This guarantees no partial ce_cpu/ce_cpu_f2 pair.
- Pause: hold_ack = paused.
  - Assertion takes effect at the next boundary; deassertion likewise waits for the boundary.
  - Video and timer enables never pause.
- Simultaneous events: speed change and hold change at the same boundary both apply.
- Mid-run reset: all outputs drop to 0 immediately, asynchronously, and the start-up sequence repeats.
- Ordering: the ce_cpu → ce_cpu_f2 ordering is always preserved; an orphan ce_cpu_f2 is illegal.

Decomposition:
- Shared package vector_clk_pkg holds:
  - speed encoding constants SPD_3M, SPD_6M, SPD_1M5;
  - the boundary constant 4'b1111;
  - the CPU phase decode constants.
- One natural sub-module: vector_cegen_cpu. It contains the speed/pause latch and the CPU enable decode, taking ctr[3:0] and producing ce_cpu, ce_cpu_f2 and hold_ack.

Test Plan:
1. Reset and start-up, with INIT_CYCLES=3: release reset_n → ready rises after edge 3, first ce12=1 after edge 5, and all enables are 0 before that.
2. Rate check per speed over 256 counting clocks:
   - cpu_speed=0 → 32 ce_cpu pulses; =1 → 64; =2 → 16; =3 → 32.
   - Every ce_cpu is followed exactly one clock later by ce_cpu_f2.
3. Fixed enables over 256 clocks:
   - ce12=128, ce6=64, ce6x=64, ce1m5=16 pulses, video_slice high for 128 clocks.
   - pipe_ab toggles every 32 clocks (CTR_W=6).
4. Mid-window speed change: switch 0→1 at ctr=5 → the old rate persists until ctr wraps to 0 mod 16, and there are no runt or double pulses.
5. Pause handshake: raise hold_req at ctr=3 → hold_ack rises after the ctr[3:0]=15 edge and CPU enables stop. Drop hold_req → enables resume at the next window while video enables are uninterrupted throughout.
6. Reset mid-run: assert reset_n low at ctr=37 → all outputs 0 within the same cycle, and scenario 1 timing repeats on release.

Source files
------------

// File: rtl/vector_clk_pkg.sv
// rtl/vector_clk_pkg.sv - Shared speed encodings and phase decode constants for the Vector-06C enable generator
package vector_clk_pkg;

  typedef enum logic [1:0] {
    SPD_3M  = 2'd0,
    SPD_6M  = 2'd1,
    SPD_1M5 = 2'd2
  } speed_t;

  localparam logic [3:0] WIN_END  = 4'b1111;
  localparam logic [3:0] TMR_PH   = 4'b0110;
  localparam logic [1:0] PH6_F1   = 2'b10;
  localparam logic [1:0] PH6_F2   = 2'b11;
  localparam logic [2:0] PH3_F1   = 3'b110;
  localparam logic [2:0] PH3_F2   = 3'b111;
  localparam logic [3:0] PH1M5_F1 = 4'b0110;
  localparam logic [3:0] PH1M5_F2 = 4'b0111;

  // Encoding 3 is unused and folds onto the 3 MHz rate.
  function automatic speed_t norm_speed(input logic [1:0] s);
    speed_t r;
    r = SPD_3M;
    case (s)
      2'd1:    r = SPD_6M;
      2'd2:    r = SPD_1M5;
      default: r = SPD_3M;
    endcase
    return r;
  endfunction

  function automatic logic cpu_hit(input speed_t s, input logic [3:0] c, input logic f2);
    logic r;
    r = 1'b0;
    case (s)
      SPD_6M:  r = (c[1:0] == (f2 ? PH6_F2 : PH6_F1));
      SPD_1M5: r = (c == (f2 ? PH1M5_F2 : PH1M5_F1));
      default: r = (c[2:0] == (f2 ? PH3_F2 : PH3_F1));
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_cegen_if.sv
// rtl/vector_cegen_if.sv - Control inputs and enable outputs of the clock-enable generator
interface vector_cegen_if #(
  parameter int CTR_W = 6
);
  logic [1:0]       cpu_speed;
  logic             hold_req;
  logic             hold_ack;
  logic             ready;
  logic             ce12;
  logic             ce6;
  logic             ce6x;
  logic             video_slice;
  logic             pipe_ab;
  logic             ce_cpu;
  logic             ce_cpu_f2;
  logic             ce1m5;
  logic [CTR_W-1:0] phase;

  modport master (
    input  cpu_speed, hold_req,
    output hold_ack, ready, ce12, ce6, ce6x, video_slice, pipe_ab,
           ce_cpu, ce_cpu_f2, ce1m5, phase
  );

  modport slave (
    output cpu_speed, hold_req,
    input  hold_ack, ready, ce12, ce6, ce6x, video_slice, pipe_ab,
           ce_cpu, ce_cpu_f2, ce1m5, phase
  );
endinterface

// File: rtl/vector_cegen_cpu.sv
// rtl/vector_cegen_cpu.sv - CPU enable pair with speed/pause latched only at the 16-clock window boundary
module vector_cegen_cpu
  import vector_clk_pkg::*;
#(
  parameter logic [1:0] DEFAULT_SPEED = 2'd0
) (
  input  logic       clk24,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] ctr4,
  input  logic [1:0] cpu_speed,
  input  logic       hold_req,
  output logic       ce_cpu,
  output logic       ce_cpu_f2,
  output logic       hold_ack
);
  speed_t spd_q;
  logic   paused;

  // The decode at the boundary still uses the old speed/pause, so a pair is never split.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      spd_q     <= norm_speed(DEFAULT_SPEED);
      paused    <= 1'b0;
      ce_cpu    <= 1'b0;
      ce_cpu_f2 <= 1'b0;
    end else if (en) begin
      ce_cpu    <= ~paused & cpu_hit(spd_q, ctr4, 1'b0);
      ce_cpu_f2 <= ~paused & cpu_hit(spd_q, ctr4, 1'b1);
      if (ctr4 == WIN_END) begin
        spd_q  <= norm_speed(cpu_speed);
        paused <= hold_req;
      end
    end
  end

  assign hold_ack = paused;

endmodule

// File: rtl/vector_cegen.sv
// rtl/vector_cegen.sv - Vector-06C clock-enable generator: start-up delay, phase counter, registered enables
module vector_cegen
  import vector_clk_pkg::*;
#(
  parameter int         CTR_W         = 6,
  parameter int         INIT_CYCLES   = 3,
  parameter logic [1:0] DEFAULT_SPEED = 2'd0
) (
  input  logic           clk24,
  input  logic           reset_n,
  vector_cegen_if.master cg
);
  localparam logic [4:0] INIT_END = 5'(INIT_CYCLES);

  logic [4:0]       init_cnt;
  logic             ready;
  logic [CTR_W-1:0] ctr;
  logic             ce12_q, ce6_q, ce6x_q, slice_q, pipe_q, ce1m5_q;
  logic             ce_cpu, ce_cpu_f2, hold_ack;

  assign ready = (init_cnt == INIT_END);

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n)    init_cnt <= '0;
    else if (!ready) init_cnt <= init_cnt + 5'd1;
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n)   ctr <= '0;
    else if (ready) ctr <= ctr + 1'b1;
  end

  // Enables trail the counter by one clock so every output is a clean flop.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      ce12_q  <= 1'b0;
      ce6_q   <= 1'b0;
      ce6x_q  <= 1'b0;
      slice_q <= 1'b0;
      pipe_q  <= 1'b0;
      ce1m5_q <= 1'b0;
    end else if (ready) begin
      ce12_q  <= ctr[0];
      ce6_q   <= ctr[1] & ctr[0];
      ce6x_q  <= ctr[1] & ~ctr[0];
      slice_q <= ~ctr[2];
      pipe_q  <= ctr[CTR_W-1];
      ce1m5_q <= (ctr[3:0] == TMR_PH);
    end
  end

  vector_cegen_cpu #(
    .DEFAULT_SPEED(DEFAULT_SPEED)
  ) u_cpu (
    .clk24    (clk24),
    .reset_n  (reset_n),
    .en       (ready),
    .ctr4     (ctr[3:0]),
    .cpu_speed(cg.cpu_speed),
    .hold_req (cg.hold_req),
    .ce_cpu   (ce_cpu),
    .ce_cpu_f2(ce_cpu_f2),
    .hold_ack (hold_ack)
  );

  assign cg.ready       = ready;
  assign cg.ce12        = ce12_q;
  assign cg.ce6         = ce6_q;
  assign cg.ce6x        = ce6x_q;
  assign cg.video_slice = slice_q;
  assign cg.pipe_ab     = pipe_q;
  assign cg.ce1m5       = ce1m5_q;
  assign cg.ce_cpu      = ce_cpu;
  assign cg.ce_cpu_f2   = ce_cpu_f2;
  assign cg.hold_ack    = hold_ack;
  assign cg.phase       = ctr;

endmodule
